pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
Parametrised program-counter unit for the TinyCPU fetch stage. It extends the plain increment/jump counter with:
- configurable address width and reset vector
- signed PC-relative branches
- a hardware call/return stack of configurable depth
- a fetch stall
- sticky stack-error flags

It drives the instruction-memory address each cycle and takes redirect commands from the decode/control unit.

Parameters:
ADDR_W, 8, width of PC and all address paths (>=2)
OFF_W, 6, width of signed branch offset (<=ADDR_W)
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_VEC, 0, PC value loaded on reset (ADDR_W bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
stall  input  1  hold PC and stack this cycle; all commands ignored
jump_en  input  1  absolute jump request
jump_addr  input  ADDR_W  target for jump and call
branch_en  input  1  relative branch request
branch_off  input  OFF_W  signed two's-complement offset added to current pc_out
call_en  input  1  push return address, go to jump_addr
ret_en  input  1  pop return address into PC
pc_out  output  ADDR_W  current program counter (registered)
stack_depth  output  $clog2(STACK_DEPTH+1)  current number of valid stack entries
stack_full  output  1  stack_depth == STACK_DEPTH
stack_empty  output  1  stack_depth == 0
ovf_err  output  1  sticky: call attempted while full
unf_err  output  1  sticky: return attempted while empty

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc_out=RESET_VEC, stack_depth=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0.
  - Stack contents are don't-care.
  - The first rising edge after deassertion is a normal update.
- Registered outputs: pc_out and stack_depth are registered. stack_full and stack_empty are combinational decodes of stack_depth. All commands take effect on the next rising edge (1-cycle latency).
- stall=1:
  - pc_out, stack, stack_depth and error flags all hold.
  - All command inputs are ignored, and no error flags are set.
- Next-PC selection when stall=0, one action per cycle, fixed priority ret_en > call_en > jump_en > branch_en > increment:
  - ret, stack not empty: pc_out <= top entry; stack_depth decrements.
  - ret, stack empty: pc_out <= pc_out+1; unf_err <= 1; stack unchanged.
  - call, stack not full: push (pc_out+1) mod 2^ADDR_W; pc_out <= jump_addr; stack_depth increments.
  - call, stack full: no push; pc_out <= pc_out+1; ovf_err <= 1.
  - jump: pc_out <= jump_addr.
  - branch: pc_out <= (pc_out + sign_extend(branch_off)) mod 2^ADDR_W.
  - none: pc_out <= (pc_out+1) mod 2^ADDR_W.
- Arithmetic: all PC arithmetic is ADDR_W bits and wraps silently. Wrap is not an error.
- Simultaneous requests: lower-priority requests in the same cycle are discarded, not queued. Example: ret_en and call_en together perform only the return.
- Stack ordering: LIFO. The entry pushed most recently is popped first. Nesting to STACK_DEPTH levels must round-trip exactly.
- Error flags: ovf_err and unf_err stay at 1 until reset; there is no other clear. A failed call/ret still advances the PC by 1, so fetch continues deterministically.
- No combinational path from any input to pc_out.

Test Plan:
1. Reset and wrap. ADDR_W=8, RESET_VEC=8'hF0: assert reset async mid-cycle -> pc_out=F0 immediately. Release, 16 idle clocks -> pc_out reaches FF then 00, 01.
2. Branch and jump.
   - pc_out=20, branch_en with branch_off=6'b111100 (-4) -> pc_out=1C.
   - Then jump_en, jump_addr=80 -> pc_out=80.
   - Then branch_off=+3 at pc FE -> 01 (wrap).
3. Call/return nesting, STACK_DEPTH=4.
   - Calls from pc 10,20,30,40 to targets 20,30,40,50 -> stack_full=1, depth=4.
   - Four rets -> pc_out 41,31,21,11 in order; stack_empty=1; no error flags.
4. Overflow and underflow.
   - Fifth call at pc 50 with full stack -> pc_out=51, ovf_err=1, depth stays 4.
   - Drain the stack, then ret at pc 60 -> pc_out=61, unf_err=1.
   - Both flags stay 1 until reset.
5. Stall and priority.
   - stall=1 with call_en=1 for 3 cycles -> pc_out, depth and flags unchanged.
   - Then stall=0 with ret_en, call_en, jump_en all asserted and depth=1 -> only the pop occurs (pc=top, depth=0).
6. Reset mid-call sequence. Depth=3, assert reset -> depth=0, stack_empty=1, pc_out=RESET_VEC. The following ret sets unf_err=1.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Program-counter unit for the TinyCPU fetch stage: increment, absolute jump,
// signed relative branch, and a call/return stack with sticky error flags.
module pc_stack_unit #(
    parameter int ADDR_W = 8,
    parameter int OFF_W = 6,
    parameter int STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               branch_en,
    input  logic [OFF_W-1:0]   branch_off,
    input  logic               call_en,
    input  logic               ret_en,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [DEPTH_W-1:0] stack_depth,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               ovf_err,
    output logic               unf_err
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  off_ext;
    logic [PTR_W-1:0]   top_idx;
    logic [PTR_W-1:0]   push_idx;
    logic               push;
    logic               full;
    logic               empty;

    generate
        if (OFF_W < ADDR_W) begin : g_sext
            assign off_ext = {{(ADDR_W - OFF_W){branch_off[OFF_W-1]}}, branch_off};
        end else begin : g_nosext
            assign off_ext = branch_off;
        end
    endgenerate

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty    = (depth_q == '0);
    // Entries occupy slots 0..depth-1, so the top sits one below the depth.
    assign top_idx  = depth_q[PTR_W-1:0] - PTR_W'(1);
    assign push_idx = depth_q[PTR_W-1:0];

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (!stall) begin
            if (ret_en) begin
                if (!empty) begin
                    pc_d    = stack_q[top_idx];
                    depth_d = depth_q - DEPTH_W'(1);
                end else begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end
            end else if (call_en) begin
                if (!full) begin
                    push    = 1'b1;
                    pc_d    = jump_addr;
                    depth_d = depth_q + DEPTH_W'(1);
                end else begin
                    pc_d  = pc_inc;
                    ovf_d = 1'b1;
                end
            end else if (jump_en) begin
                pc_d = jump_addr;
            end else if (branch_en) begin
                pc_d = pc_q + off_ext;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents are meaningless after reset since depth returns to zero.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc_out      = pc_q;
    assign stack_depth = depth_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit with ADDR_W=8, OFF_W=6, STACK_DEPTH=4,
// RESET_VEC=8'hF0; expected values are hand-computed per step.
module tb_pc_stack_unit;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       branch_en;
    logic [5:0] branch_off;
    logic       call_en;
    logic       ret_en;
    logic [7:0] pc_out;
    logic [2:0] stack_depth;
    logic       stack_full;
    logic       stack_empty;
    logic       ovf_err;
    logic       unf_err;

    int checks = 0;
    int errors = 0;

    pc_stack_unit #(
        .ADDR_W(8),
        .OFF_W(6),
        .STACK_DEPTH(4),
        .RESET_VEC(8'hF0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .jump_en(jump_en),
        .jump_addr(jump_addr),
        .branch_en(branch_en),
        .branch_off(branch_off),
        .call_en(call_en),
        .ret_en(ret_en),
        .pc_out(pc_out),
        .stack_depth(stack_depth),
        .stack_full(stack_full),
        .stack_empty(stack_empty),
        .ovf_err(ovf_err),
        .unf_err(unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cmds();
        stall     = 1'b0;
        jump_en   = 1'b0;
        branch_en = 1'b0;
        call_en   = 1'b0;
        ret_en    = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] pc, input logic [2:0] depth,
                             input logic ovf, input logic unf);
        chk({tag, "_pc"}, pc_out, pc);
        chk({tag, "_depth"}, stack_depth, depth);
        chk({tag, "_full"}, stack_full, depth == 3'd4);
        chk({tag, "_empty"}, stack_empty, depth == 3'd0);
        chk({tag, "_ovf"}, ovf_err, ovf);
        chk({tag, "_unf"}, unf_err, unf);
    endtask

    task automatic do_jump(input logic [7:0] addr);
        jump_en = 1'b1; jump_addr = addr;
        cyc();
        jump_en = 1'b0;
    endtask

    task automatic do_call(input logic [7:0] addr);
        call_en = 1'b1; jump_addr = addr;
        cyc();
        call_en = 1'b0;
    endtask

    task automatic do_ret();
        ret_en = 1'b1;
        cyc();
        ret_en = 1'b0;
    endtask

    initial begin
        idle_cmds();
        jump_addr  = 8'h00;
        branch_off = 6'h00;
        reset      = 1'b1;
        #12;
        reset = 1'b0;
        chk_state("reset", 8'hF0, 3'd0, 1'b0, 1'b0);

        // Idle increment and wrap through FF -> 00 -> 01.
        for (int i = 0; i < 15; i++) cyc();
        chk("wrap_ff", pc_out, 8'hFF);
        cyc();
        chk("wrap_00", pc_out, 8'h00);
        cyc();
        chk("wrap_01", pc_out, 8'h01);

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        #4;
        reset = 1'b1;
        #1;
        chk("async_reset_pc", pc_out, 8'hF0);
        reset = 1'b0;
        cyc();
        chk("after_reset_inc", pc_out, 8'hF1);

        // Branch and jump.
        do_jump(8'h20);
        chk("jump_20", pc_out, 8'h20);
        branch_en = 1'b1; branch_off = 6'b111100;
        cyc();
        branch_en = 1'b0;
        chk("branch_neg4", pc_out, 8'h1C);
        do_jump(8'h80);
        chk("jump_80", pc_out, 8'h80);
        do_jump(8'hFE);
        branch_en = 1'b1; branch_off = 6'd3;
        cyc();
        branch_en = 1'b0;
        chk("branch_wrap", pc_out, 8'h01);

        // Four nested calls fill the stack, four returns unwind it in LIFO order.
        do_jump(8'h10);
        do_call(8'h20);
        chk_state("call1", 8'h20, 3'd1, 1'b0, 1'b0);
        do_call(8'h30);
        do_call(8'h40);
        do_call(8'h50);
        chk_state("call4", 8'h50, 3'd4, 1'b0, 1'b0);
        do_ret();
        chk("ret1", pc_out, 8'h41);
        do_ret();
        chk("ret2", pc_out, 8'h31);
        do_ret();
        chk("ret3", pc_out, 8'h21);
        do_ret();
        chk_state("ret4", 8'h11, 3'd0, 1'b0, 1'b0);

        // Overflow: fifth call with full stack advances PC by one only.
        do_jump(8'h10);
        do_call(8'h20);
        do_call(8'h30);
        do_call(8'h40);
        do_call(8'h50);
        do_call(8'h77);
        chk_state("ovf", 8'h51, 3'd4, 1'b1, 1'b0);
        do_ret();
        chk("ovf_ret1", pc_out, 8'h41);
        do_ret();
        chk("ovf_ret2", pc_out, 8'h31);
        do_ret();
        chk("ovf_ret3", pc_out, 8'h21);
        do_ret();
        chk_state("ovf_ret4", 8'h11, 3'd0, 1'b1, 1'b0);

        // Underflow: ret with empty stack advances PC by one.
        do_jump(8'h60);
        do_ret();
        chk_state("unf", 8'h61, 3'd0, 1'b1, 1'b1);
        cyc();
        cyc();
        chk_state("flags_sticky", 8'h63, 3'd0, 1'b1, 1'b1);

        // Stall holds everything and ignores commands.
        do_jump(8'h90);
        do_call(8'hA0);
        chk_state("pre_stall", 8'hA0, 3'd1, 1'b1, 1'b1);
        stall = 1'b1; call_en = 1'b1; jump_addr = 8'hC0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_state($sformatf("stall%0d", i), 8'hA0, 3'd1, 1'b1, 1'b1);
        end

        // Priority: ret beats call and jump.
        stall = 1'b0; ret_en = 1'b1; call_en = 1'b1; jump_en = 1'b1;
        cyc();
        idle_cmds();
        chk_state("priority_ret", 8'h91, 3'd0, 1'b1, 1'b1);

        // Reset in the middle of a call sequence.
        do_jump(8'h10);
        do_call(8'h20);
        do_call(8'h30);
        do_call(8'h40);
        chk("depth3", stack_depth, 3'd3);
        #4;
        reset = 1'b1;
        #1;
        chk_state("mid_reset", 8'hF0, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // A stalled ret on an empty stack must not set the underflow flag.
        stall = 1'b1; ret_en = 1'b1;
        cyc();
        cyc();
        chk_state("stall_ret", 8'hF0, 3'd0, 1'b0, 1'b0);
        stall = 1'b0;
        cyc();
        ret_en = 1'b0;
        chk_state("post_reset_unf", 8'hF1, 3'd0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
